// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding plus the default frame and oversample
// constants common to the transmitter, receiver and baud generator.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receiver-side bundle: oversample enable and serial line in, byte stream and status out.
// master = the receive engine, slave = the line/tick source and byte consumer.
interface uart_rx_oversample_if #(
    parameter int unsigned DATA_BITS = uart_pkg::UART_DATA_BITS
) ();

    logic                 os_tick;
    logic                 rxd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        input  os_tick, rxd,
        output data_out, data_valid, frame_err, parity_err, busy
    );

    modport slave (
        output os_tick, rxd,
        input  data_out, data_valid, frame_err, parity_err, busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receive engine (LSB-first, one stop bit). Defining UART_RX_PARITY_EN
// adds an even-parity bit after the data bits and makes parity_err live.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_oversample_if.master bus
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);

    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rxd_s;
    logic                 at_last;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.rxd),
        .q    (rxd_s)
    );

    // os_tick that lands in the middle of the current bit (tick counter aligned at start)
    assign at_last = bus.os_tick && (tick_q == TickLast);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (bus.os_tick) begin
            tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.os_tick && !rxd_s) state_d = StStart;
            end
            StStart: begin
                if (bus.os_tick && (tick_q == TickMid)) begin
                    state_d = rxd_s ? StIdle : StData;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            StData: begin
                if (at_last) begin
                    shift_d[bit_q] = rxd_s;
                    if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_last) begin
                    par_bad_d = (rxd_s != ^shift_q);
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (at_last) begin
                    data_d  = shift_q;
                    ferr_d  = !rxd_s;
                    state_d = rxd_s ? StIdle : StBreak;
`ifdef UART_RX_PARITY_EN
                    valid_d = rxd_s && !par_bad_q;
                    perr_d  = par_bad_q;
`else
                    valid_d = rxd_s;
`endif
                end
            end
            StBreak: begin
                if (rxd_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) tick_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
